// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the wait-state data memory (data_mem_ws).
//   state_t    : controller state (sweep clear, idle, counting wait states)
//   WAIT_CW    : width of the wait-state counter (covers 0..15)
//   lane_count : number of byte lanes in a data word
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int WAIT_CW = 4;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// ---------------------------------------------------------------------------
// dmem_ram_bank
// Single-port storage array: one synchronous write port with byte-lane
// enables and one synchronous, registered read. The controller guarantees
// that a read and a write never execute on the same edge.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (clears the read register only)
//   wr_en  : write strobe for this edge
//   be     : byte-lane enables for the write
//   addr   : word address shared by read and write
//   wdata  : write data
//   rd_en  : read strobe; rdata loads mem[addr] on this edge
//   rdata  : registered read data, held between reads
// ---------------------------------------------------------------------------
module dmem_ram_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [lane_count(DATA_W)-1:0]    be,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic                             rd_en,
    output logic [DATA_W-1:0]                rdata
);

    localparam int LANES = lane_count(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; a reset branch would turn it into
    // flops. Zeroing is done by the controller's clear sweep instead.
    // NOTE: clocked state is always assigned with <= so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ws.sv
// ---------------------------------------------------------------------------
// data_mem_ws
// Data memory with req/ack handshake, WAIT programmable wait states,
// byte-lane writes and an optional post-reset zeroing sweep.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   req    : access request, sampled only when idle
//   we     : 1 = write, 0 = read
//   be     : byte-lane write enables (ignored on reads)
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data, held until the next read executes
//   ack    : one-cycle pulse per completed access
//   busy   : high while sweeping or counting wait states
// ---------------------------------------------------------------------------
module data_mem_ws
    import dmem_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int WAIT           = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ack,
    output logic                  busy
);

    localparam int                 LANES       = lane_count(DATA_W);
    localparam logic [WAIT_CW-1:0] WAIT_INIT   = WAIT_CW'(WAIT);
    localparam state_t             RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    if ((DATA_W % 8) != 0 || WAIT < 0 || WAIT > 15) begin : g_param_check
        $error("data_mem_ws: DATA_W must be a multiple of 8 and WAIT must be within 0..15");
    end

    state_t              state;
    state_t              state_next;
    logic [WAIT_CW-1:0]  wait_cnt;
    logic [ADDR_W-1:0]   clr_cnt;

    logic                cap_we;
    logic [LANES-1:0]    cap_be;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;

    logic                accept;
    logic                exec;
    logic                acc_we;
    logic [LANES-1:0]    acc_be;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;

    logic                ram_wr_en;
    logic                ram_rd_en;
    logic [LANES-1:0]    ram_be;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;

    assign accept = (state == ST_IDLE) && req;

    // With no wait states the access runs on the acceptance edge straight from
    // the ports; otherwise it runs from the captured copy when the count hits 1.
    assign exec = (WAIT == 0) ? accept
                              : ((state == ST_WAIT) && (wait_cnt == WAIT_CW'(1)));

    assign acc_we    = (WAIT == 0) ? we    : cap_we;
    assign acc_be    = (WAIT == 0) ? be    : cap_be;
    assign acc_addr  = (WAIT == 0) ? addr  : cap_addr;
    assign acc_wdata = (WAIT == 0) ? wdata : cap_wdata;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_CLEAR: if (clr_cnt == '1)                 state_next = ST_IDLE;
            ST_IDLE:  if (req && (WAIT != 0))            state_next = ST_WAIT;
            ST_WAIT:  if (wait_cnt == WAIT_CW'(1))       state_next = ST_IDLE;
            default:                                     state_next = RESET_STATE;
        endcase
    end

    // Output / RAM-port logic: the single write port serves the sweep while
    // clearing and the executing access otherwise.
    always_comb begin
        busy      = (state != ST_IDLE);
        ram_wr_en = 1'b0;
        ram_rd_en = 1'b0;
        ram_be    = acc_be;
        ram_addr  = acc_addr;
        ram_wdata = acc_wdata;
        if (state == ST_CLEAR) begin
            ram_wr_en = 1'b1;
            ram_be    = '1;
            ram_addr  = clr_cnt;
            ram_wdata = '0;
        end else if (exec) begin
            ram_wr_en = acc_we;
            ram_rd_en = !acc_we;
        end
    end

    // Sweep and wait-state counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            clr_cnt  <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (accept) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Request capture; only read while in ST_WAIT, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= we;
            cap_be    <= be;
            cap_addr  <= addr;
            cap_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= exec;
        end
    end

    dmem_ram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .wr_en (ram_wr_en),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rd_en (ram_rd_en),
        .rdata (rdata)
    );

endmodule

// File: doc/data_mem_ws.md
# data_mem_ws

Parametrised single-port data memory with a request/acknowledge handshake, programmable wait states, byte-lane write enables and a post-reset clear sweep. It replaces the fixed 8-bit, zero-latency data memory on the processor's load/store path. The core's memory stage issues one request and stalls until `ack`. Generalised data/address width and latency let the same block serve the 16-bit datapath and slower memory models.

## Interface
- `DATA_W`, 16: data width in bits; must be a multiple of 8.
- `ADDR_W`, 8: word-address width; depth = 2**ADDR_W words.
- `WAIT`, 1: extra wait states per access, 0..15.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset; 0 = skip sweep, contents undefined.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  access request, sampled only when accepting.
- `we`  in  1  1 = write, 0 = read.
- `be`  in  DATA_W/8  byte-lane write enables; ignored on reads.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  read data, registered.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while clear sweep or wait states are in progress.

## Operation
- States: CLEAR, IDLE, WAIT.
- Reset values:
  - `ack`=0, `rdata`=0, wait counter=0, clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - `busy`=1 in CLEAR.
- CLEAR:
  - Writes 0 to `mem[clr_cnt]` each cycle; `clr_cnt` increments.
  - After writing address 2**ADDR_W-1, goes to IDLE. Sweep takes exactly 2**ADDR_W cycles.
  - `req` is ignored and never acknowledged.
- Acceptance: on a rising edge with state==IDLE and `req`=1.
  - `we`, `be`, `addr` and `wdata` are captured; later input changes have no effect.
- WAIT==0:
  - The access executes on the acceptance edge.
  - State stays IDLE; `ack`=1 for the next cycle.
- WAIT>0:
  - Go to WAIT with counter=WAIT.
  - Decrement each edge. On the edge where the counter is 1, execute the access, set `ack`=1 and return to IDLE.
- Write access:
  - For each lane i with `be[i]`=1, `mem[addr][8i+7:8i]` ← `wdata[8i+7:8i]`; other lanes are unchanged.
  - `rdata` holds its previous value.
- Read access: `rdata` ← `mem[addr]` on the execute edge; held until the next read executes.
- `ack` is high for exactly one cycle per accepted request and is never high in CLEAR.
- `busy` = (state != IDLE).

## Timing
- Acceptance edge E0 → `ack` high in the cycle after edge E0+WAIT, i.e. latency WAIT+1 cycles.
- Back-to-back: a request present during an `ack` cycle is accepted on that cycle's edge. Sustained throughput is one access per WAIT+1 cycles.
- Read-after-write to the same address in consecutive requests returns the new data.
- `be`=0 write: acknowledged normally, memory unchanged.
- Reset mid-operation:
  - A pending (unexecuted) access is discarded and `ack` drops immediately.
  - Memory contents are not altered asynchronously; CLEAR rezeroes them if enabled.
- Reset during CLEAR restarts the sweep at address 0.
- No read-during-write hazard: only one access executes per edge.

## Structure
- Package `dmem_pkg`: state enum (CLEAR, IDLE, WAIT), `WAIT_CW` = 4 counter width, and a lane-count function `DATA_W/8`.
- Elaboration-time check: `DATA_W % 8 == 0` and `WAIT <= 15`.
- Sub-module `dmem_ram_bank`:
  - Storage array with per-lane synchronous write and synchronous registered read.
  - One write port, muxed between clear and access.
- Top module holds the FSM, counters, capture registers and `ack`/`busy` generation.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=8: `busy`=1 for 256 cycles, `req` ignored. Then reads of addresses 0x00, 0x7F and 0xFF return 0x0000.
- WAIT=0: write 0xBEEF to addr 0x10 with `be`=2'b11, then read 0x10 back-to-back. `ack` pulses on consecutive cycles and the read returns 0xBEEF.
- Byte lanes: write 0x1234 to 0x20; write 0xAB00 with `be`=2'b10; read returns 0xAB34. Write with `be`=2'b00 is acked and the read still returns 0xAB34.
- WAIT=3: read accepted at edge E0 → `ack` high only in the cycle after edge E0+3. Toggling `addr` during WAIT does not change the returned data.
- Assert `rst` during WAIT of a write to 0x05 (stored value 0x1111, CLEAR_ON_RESET=0): no `ack`, and a later read of 0x05 returns 0x1111.
- Hold `req` high continuously with WAIT=2: one `ack` every 3 cycles, and `rdata` is stable between acks.
